// File: rtl/uart_dbus_bridge_pkg.sv
// Shared types and constants for the UART-to-dbus bridge.
// RESP_TMO exists only when UART_DBUS_BRIDGE_TIMEOUT_EN is defined.
package uart_dbus_bridge_pkg;

  localparam logic [7:0] OPC_WR_DEF = 8'h57;
  localparam logic [7:0] OPC_RD_DEF = 8'h52;
  localparam logic [7:0] RESP_OK    = 8'h4B;
  localparam logic [7:0] RESP_ERR   = 8'h3F;
`ifdef UART_DBUS_BRIDGE_TIMEOUT_EN
  localparam logic [7:0] RESP_TMO   = 8'h54;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_BUS,
    ST_RESP
  } type_bridge_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] w_data;
    logic        w_en;
    logic        req;
  } type_dbus2peri_s;

  typedef struct packed {
    logic [31:0] r_data;
    logic        ack;
  } type_peri2dbus_s;

  // dbus is word-addressed only
  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/uart_dbus_bridge_if.sv
// dbus request/response channel between an initiator (master) and a peripheral (slave).
interface uart_dbus_bridge_if;
  import uart_dbus_bridge_pkg::*;

  type_dbus2peri_s dbus2peri;
  type_peri2dbus_s peri2dbus;

  modport master (output dbus2peri, input peri2dbus);
  modport slave  (input dbus2peri, output peri2dbus);

endinterface

// File: rtl/uart_bridge_tx_ser.sv
// Response serializer: loads up to four bytes and pushes them LSB first into the TX FIFO,
// stalling while the FIFO is full; done pulses in the cycle the last byte is pushed.
module uart_bridge_tx_ser (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic [2:0]  load_cnt,
  input  logic        fifo_full,
  output logic        fifo_write,
  output logic [7:0]  data,
  output logic        done
);

  logic [31:0] shift_q;
  logic [2:0]  left_q;
  logic        push;

  assign push       = (left_q != 3'd0) && !fifo_full;
  assign fifo_write = push;
  assign data       = shift_q[7:0];
  assign done       = push && (left_q == 3'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      left_q  <= '0;
    end else if (load) begin
      shift_q <= load_data;
      left_q  <= load_cnt;
    end else if (push) begin
      shift_q <= {8'h00, shift_q[31:8]};
      left_q  <= left_q - 3'd1;
    end
  end

endmodule

// File: rtl/uart_dbus_bridge.sv
// UART-driven dbus initiator: parses W/R command frames from the RX FIFO, issues one dbus
// access per frame and answers through the TX FIFO. Optional ack timeout: UART_DBUS_BRIDGE_TIMEOUT_EN.
module uart_dbus_bridge
  import uart_dbus_bridge_pkg::*;
#(
  parameter logic [7:0] OPC_WR = OPC_WR_DEF,
  parameter logic [7:0] OPC_RD = OPC_RD_DEF
`ifdef UART_DBUS_BRIDGE_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                      clk,
  input  logic                      rst_n,
  uart_dbus_bridge_if.master        dbus,
  input  logic                      rx_fifo_empty_i,
  input  logic [7:0]                rx_fifo_data_i,
  output logic                      rx_fifo_read_o,
  input  logic                      tx_fifo_full_i,
  output logic                      tx_fifo_write_o,
  output logic [7:0]                tx_data_o,
  output logic                      busy_o
);

  type_bridge_state_e state_q, state_d;
  logic [1:0]  cnt_q;
  logic        is_wr_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        req_q;
  logic        w_en_q;

  logic        bus_start;
  logic        bus_end;
  logic        ld;
  logic [31:0] ld_data;
  logic [2:0]  ld_cnt;
  logic        tx_done;
  logic        timeout;

`ifdef UART_DBUS_BRIDGE_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                tmo_q <= '0;
    else if (state_q != ST_BUS) tmo_q <= '0;
    else                       tmo_q <= tmo_q + 1'b1;
  end

  // req is held for exactly TIMEOUT_CYCLES cycles before the abort
  assign timeout = (state_q == ST_BUS) && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    rx_fifo_read_o = 1'b0;
    bus_start      = 1'b0;
    bus_end        = 1'b0;
    ld             = 1'b0;
    ld_data        = '0;
    ld_cnt         = 3'd1;
    case (state_q)
      ST_IDLE: begin
        rx_fifo_read_o = !rx_fifo_empty_i;
        if (!rx_fifo_empty_i) begin
          if (rx_fifo_data_i == OPC_WR || rx_fifo_data_i == OPC_RD) begin
            state_d = ST_ADDR;
          end else begin
            ld      = 1'b1;
            ld_data = {24'h0, RESP_ERR};
            state_d = ST_RESP;
          end
        end
      end
      ST_ADDR: begin
        rx_fifo_read_o = !rx_fifo_empty_i;
        if (!rx_fifo_empty_i && cnt_q == 2'd3) begin
          if (is_wr_q) begin
            state_d = ST_DATA;
          end else begin
            state_d   = ST_BUS;
            bus_start = 1'b1;
          end
        end
      end
      ST_DATA: begin
        rx_fifo_read_o = !rx_fifo_empty_i;
        if (!rx_fifo_empty_i && cnt_q == 2'd3) begin
          state_d   = ST_BUS;
          bus_start = 1'b1;
        end
      end
      ST_BUS: begin
        if (dbus.peri2dbus.ack) begin
          bus_end = 1'b1;
          ld      = 1'b1;
          ld_data = is_wr_q ? {24'h0, RESP_OK} : dbus.peri2dbus.r_data;
          ld_cnt  = is_wr_q ? 3'd1 : 3'd4;
          state_d = ST_RESP;
        end else if (timeout) begin
          bus_end = 1'b1;
          ld      = 1'b1;
`ifdef UART_DBUS_BRIDGE_TIMEOUT_EN
          ld_data = {24'h0, RESP_TMO};
`endif
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (tx_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      is_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      req_q   <= 1'b0;
      w_en_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE) begin
        cnt_q <= '0;
        if (!rx_fifo_empty_i) is_wr_q <= (rx_fifo_data_i == OPC_WR);
      end else if (rx_fifo_read_o) begin
        cnt_q <= cnt_q + 2'd1;
      end
      // little-endian assembly: each new byte enters at the top and walks down
      if (state_q == ST_ADDR && rx_fifo_read_o) addr_q  <= {rx_fifo_data_i, addr_q[31:8]};
      if (state_q == ST_DATA && rx_fifo_read_o) wdata_q <= {rx_fifo_data_i, wdata_q[31:8]};
      if (bus_start) begin
        req_q  <= 1'b1;
        w_en_q <= is_wr_q;
      end else if (bus_end) begin
        req_q  <= 1'b0;
        w_en_q <= 1'b0;
      end
    end
  end

  assign dbus.dbus2peri = '{addr: word_addr(addr_q), w_data: wdata_q, w_en: w_en_q, req: req_q};
  assign busy_o         = (state_q != ST_IDLE);

  uart_bridge_tx_ser u_tx_ser (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (ld),
    .load_data  (ld_data),
    .load_cnt   (ld_cnt),
    .fifo_full  (tx_fifo_full_i),
    .fifo_write (tx_fifo_write_o),
    .data       (tx_data_o),
    .done       (tx_done)
  );

endmodule
